// File: rtl/axi_lite_pkt_arbiter_pkg.sv
// axi_lite_pkt_pkg: shared states and constants for the AXI-Lite packet arbiter.
package axi_lite_pkt_pkg;
    typedef enum logic [2:0] {IDLE, D_AW, D_W, D_B, C_AW, C_W, C_B, RESP} state_e;
    localparam logic [7:0] COMMIT_ADDR_DEF = 8'h04;
    localparam logic [7:0] HDR_VALID       = 8'hA5;
    localparam logic [7:0] HDR_INVALID     = 8'hFF;
endpackage

// File: rtl/axi_lite_pkt_arbiter_if.sv
// axi_lite_pkt_arbiter_if: AXI-Lite aw/w/b channels between the arbiter and the packet slave.
interface axi_lite_pkt_arbiter_if;
    logic [7:0]  aw_addr;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] w_data;
    logic        w_valid;
    logic        w_ready;
    logic        b_response;
    logic        b_valid;
    logic        b_ready;
    modport master (
        output aw_addr, aw_valid, w_data, w_valid, b_ready,
        input  aw_ready, w_ready, b_response, b_valid
    );
    modport slave (
        input  aw_addr, aw_valid, w_data, w_valid, b_ready,
        output aw_ready, w_ready, b_response, b_valid
    );
endinterface

// File: rtl/axi_lite_pkt_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      gnt_idx_o
);
    logic [IW:0] s;
    logic        found;
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        s         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            s = {1'b0, ptr_i} + (IW+1)'(k);
            s = (s >= (IW+1)'(NUM_REQ)) ? s - (IW+1)'(NUM_REQ) : s;
            if (!found && req_i[s[IW-1:0]]) begin
                found             = 1'b1;
                gnt_idx_o         = s[IW-1:0];
                gnt_o[s[IW-1:0]]  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/axi_lite_pkt_arbiter.sv
// axi_lite_pkt_arbiter: round-robin sharing of one AXI-Lite packet slave (packet write + commit write).
// Optional B_TIMEOUT_EN aborts a sequence after TIMEOUT_CYCLES without b_valid.
module axi_lite_pkt_arbiter
    import axi_lite_pkt_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter logic [7:0] COMMIT_ADDR = COMMIT_ADDR_DEF,
    localparam int IW = $clog2(NUM_REQ)
`ifdef B_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 10
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [8*NUM_REQ-1:0]   req_addr_i,
    input  logic [32*NUM_REQ-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]     rsp_valid_o,
    output logic                   rsp_ok_o,
    output logic                   rsp_timeout_o,
    output logic                   busy_o,
    axi_lite_pkt_arbiter_if.master bus
);
    state_e              state_q, state_d;
    logic [IW-1:0]       ptr_q, g_q, gnt_idx;
    logic [NUM_REQ-1:0]  gnt;
    logic [7:0]          addr_q;
    logic [31:0]         data_q;
    logic                ok_q, ok_d, tmo_hit;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i(req_valid_i), .ptr_i(ptr_q), .gnt_o(gnt), .gnt_idx_o(gnt_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ok_q    <= ok_d;
            if (state_q == IDLE && |req_valid_i) begin
                g_q    <= gnt_idx;
                addr_q <= req_addr_i[{gnt_idx, 3'b000} +: 8];
                data_q <= req_data_i[{gnt_idx, 5'b00000} +: 32];
            end
            if (state_q == RESP)
                ptr_q <= (g_q == IW'(NUM_REQ-1)) ? '0 : g_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ok_d    = ok_q;
        case (state_q)
            IDLE: begin
                state_d = |req_valid_i ? D_AW : IDLE;
                ok_d    = 1'b0;
            end
            D_AW: state_d = bus.aw_ready ? D_W : D_AW;
            D_W:  state_d = bus.w_ready ? D_B : D_W;
            D_B:  state_d = bus.b_valid ? C_AW : tmo_hit ? RESP : D_B;
            C_AW: state_d = bus.aw_ready ? C_W : C_AW;
            C_W:  state_d = bus.w_ready ? C_B : C_W;
            C_B: begin
                state_d = (bus.b_valid || tmo_hit) ? RESP : C_B;
                ok_d    = bus.b_valid ? bus.b_response : ok_q;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // req_ready is gated by rst_n so it reads 0 during reset even with requests pending
    assign req_ready_o  = (rst_n && state_q == IDLE) ? gnt : '0;
    assign busy_o       = state_q != IDLE;
    assign rsp_valid_o  = (state_q == RESP) ? NUM_REQ'(1) << g_q : '0;
    assign rsp_ok_o     = state_q == RESP && ok_q;
    assign bus.aw_valid = state_q == D_AW || state_q == C_AW;
    assign bus.aw_addr  = state_q == D_AW ? addr_q : state_q == C_AW ? COMMIT_ADDR : '0;
    assign bus.w_valid  = state_q == D_W || state_q == C_W;
    assign bus.w_data   = state_q == D_W ? data_q : '0;
    assign bus.b_ready  = state_q == D_B || state_q == C_B;

`ifdef B_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          tmo_q, wait_b;
    assign wait_b  = bus.b_ready && !bus.b_valid;
    assign tmo_hit = wait_b && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= wait_b ? cnt_q + 1'b1 : '0;
            tmo_q <= state_q == IDLE ? 1'b0 : tmo_hit ? 1'b1 : tmo_q;
        end
    end
    assign rsp_timeout_o = state_q == RESP && tmo_q;
`else
    assign tmo_hit       = 1'b0;
    assign rsp_timeout_o = 1'b0;
`endif
endmodule

// File: doc/axi_lite_pkt_arbiter.md
Name: axi_lite_pkt_arbiter

Overview:
Round-robin scheduler that shares one AXI-Lite packet validator/sorter slave between NUM_REQ packet sources. Each granted request runs a two-transaction sequence on the slave: a packet write, then a commit write to COMMIT_ADDR. The arbiter returns the slave's commit response to the winning requester. It sits between the packet producers and the slave's aw/w/b channels and is the only master on that port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
COMMIT_ADDR, 8'h04, slave commit register address
TIMEOUT_CYCLES, 10, maximum cycles to wait for b_valid per transaction (B_TIMEOUT_EN only)

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock; asynchronous, active-low
req_valid  in  NUM_REQ  per-requester packet request
req_ready  out  NUM_REQ  one-hot; request accepted this cycle
req_addr  in  8*NUM_REQ  packet write address; slice i belongs to requester i
req_data  in  32*NUM_REQ  packet word: [31:24] header, [23:0] payload
rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse; response for requester i
rsp_ok  out  1  commit b_response; valid while rsp_valid is nonzero
rsp_timeout  out  1  sequence aborted on timeout; valid with rsp_valid
busy  out  1  high from grant until the rsp pulse
aw_addr  out  8  slave write address
aw_valid  out  1  slave address valid
aw_ready  in  1  slave address ready
w_data  out  32  slave write data
w_valid  out  1  slave data valid
w_ready  in  1  slave data ready
b_response  in  1  slave response (1 = packet accepted)
b_valid  in  1  slave response valid
b_ready  out  1  response ready

Behaviour:
- Reset values: all outputs 0; RR pointer = 0; state IDLE.
- Handshakes: a transfer occurs on a cycle where valid and ready are both high at posedge. aw_valid and w_valid hold with stable addr/data until accepted and never drop early.
- State machine and transitions:
  - IDLE: if any req_valid is high, the RR arbiter grants the first requester at or after ptr. req_ready[g] pulses for one cycle. req_addr[g] and req_data[g] are latched. Next state: D_AW.
  - D_AW: aw_addr = latched addr, aw_valid = 1. Moves to D_W on aw_ready.
  - D_W: w_data = latched data, w_valid = 1. Moves to D_B on w_ready.
  - D_B: b_ready = 1. Moves to C_AW on b_valid; the b_response value is discarded.
  - C_AW: aw_addr = COMMIT_ADDR. Moves to C_W on aw_ready.
  - C_W: w_data = 32'h0. Moves to C_B on w_ready.
  - C_B: b_ready = 1. On b_valid, b_response is captured into rsp_ok. Next state: RESP.
  - RESP: rsp_valid[g] = 1 for one cycle. ptr = (g+1) mod NUM_REQ. Next state: IDLE.
- Latency: grant to aw_valid is 1 cycle. With an always-ready slave and 1-cycle b_valid, grant to rsp_valid is 9 cycles minimum.
- Only one sequence is outstanding at a time. New requests are ignored (req_ready = 0) while busy. A requester keeps req_valid high until it sees req_ready.
- A request that drops req_valid before being granted is not served, and no response is issued.
- Simultaneous requests: the RR order is strictly after the last grant. The pointer advances only at RESP.
- A b_valid arriving outside D_B/C_B is ignored; b_ready stays 0 there.
- Reset mid-sequence: immediate return to IDLE with all outputs 0. The slave is responsible for discarding a partial packet.

Optional Feature:
B_TIMEOUT_EN
- Defined: a counter clears on entry to D_B/C_B and increments each cycle without b_valid. On reaching TIMEOUT_CYCLES the arbiter jumps to RESP with rsp_ok = 0 and rsp_timeout = 1; the commit is skipped if the timeout happened in D_B.
- Undefined: the arbiter waits indefinitely, rsp_timeout is tied 0, and no counter is instantiated.

Decomposition:
- Package axi_lite_pkt_pkg holds:
  - the state enum (IDLE, D_AW, D_W, D_B, C_AW, C_W, C_B, RESP);
  - the COMMIT_ADDR default;
  - header constants: HDR_VALID = 8'hA5, HDR_INVALID example 8'hFF.
- Sub-module rr_arbiter(NUM_REQ): inputs req and ptr; outputs a one-hot grant and grant index, purely combinational. The FSM and latches stay in the top.

Test Plan:
- Single request: requester 0, addr 8'h00, data 32'hA5001122, slave returns commit b_response = 1 → aw sequence 8'h00 then 8'h04, w sequence A5001122 then 00000000, rsp_valid = 4'b0001 with rsp_ok = 1.
- Invalid header: requester 1, addr 8'h08, data 32'hFF334455, slave returns 0 → rsp_valid = 4'b0010 with rsp_ok = 0, rsp_timeout = 0.
- Contention: all four req_valid high from reset → grants in order 0,1,2,3. Then with only requesters 0 and 2 re-requesting → next grants are 0 then 2.
- Backpressure: aw_ready and w_ready held low for 5 cycles each → aw_valid/w_valid stay high with stable values, and there is exactly one transfer per phase.
- Timeout (B_TIMEOUT_EN): slave never asserts b_valid in D_B → after 10 cycles rsp_valid pulses with rsp_timeout = 1 and no commit write is issued. Without the macro, busy stays high.
- Reset mid-sequence: rst_n low during C_W → all outputs 0 asynchronously. After release, a new request restarts from D_AW and ptr is back at 0.
